// File: rtl/wallace_mult4.sv
// wallace_mult4 - 4x4 unsigned multiplier built as an explicit Wallace tree,
// with one registered output stage. The result appears one cycle after the
// operands are captured.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst        synchronous, active-high reset (priority over in_valid)
//   in_valid   qualifies a/b for capture this cycle
//   A, B       4-bit unsigned operands
//   prod       registered 8-bit unsigned product A*B
//   out_valid  high for one cycle when prod holds a fresh product
//
// Handshake: there is no backpressure. in_valid=1 at edge N produces
// out_valid=1 with the matching prod after edge N. A cycle with in_valid=0
// leaves prod unchanged and drops out_valid. One product per cycle is
// accepted with no bubbles.
//
// Reduction map (column weight in brackets, pp[i][j] = A[j] & B[i]):
//   stage 1: fa1 [2] pp02 pp11 pp20      -> s1[2]  c1[3]
//            fa2 [3] pp03 pp12 pp21      -> s2[3]  c2[4]
//            fa3 [4] pp13 pp22 pp31      -> s3[4]  c3[5]
//   stage 2: fa4 [3] pp30 s2 c1          -> s4[3]  c4[4]
//            fa5 [5] pp23 pp32 c3        -> s5[5]  c5[6]
//   stage 3: fa6 [4] s3 c2 c4            -> s6[4]  c6[5]
// After stage 3 every column holds at most two bits; a ripple-carry adder
// over columns 1..6 finishes the sum and its carry out becomes prod[7].
module wallace_mult4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] prod,
  output logic       out_valid
);

  // Partial products: pp[i][j] has weight i+j.
  logic [3:0] pp [4];

  for (genvar i = 0; i < 4; i++) begin : g_pp_row
    for (genvar j = 0; j < 4; j++) begin : g_pp_col
      assign pp[i][j] = A[j] & B[i];
    end
  end

  // Wallace reduction cells.
  logic s1, c1, s2, c2, s3, c3;
  logic s4, c4, s5, c5, s6, c6;

  // Stage 1
  wallace_fa u_fa1 (.a(pp[0][2]), .b(pp[1][1]), .cin(pp[2][0]), .s(s1), .cout(c1));
  wallace_fa u_fa2 (.a(pp[0][3]), .b(pp[1][2]), .cin(pp[2][1]), .s(s2), .cout(c2));
  wallace_fa u_fa3 (.a(pp[1][3]), .b(pp[2][2]), .cin(pp[3][1]), .s(s3), .cout(c3));

  // Stage 2
  wallace_fa u_fa4 (.a(pp[3][0]), .b(s2),       .cin(c1),       .s(s4), .cout(c4));
  wallace_fa u_fa5 (.a(pp[2][3]), .b(pp[3][2]), .cin(c3),       .s(s5), .cout(c5));

  // Stage 3
  wallace_fa u_fa6 (.a(s3),       .b(c2),       .cin(c4),       .s(s6), .cout(c6));

  // Two remaining rows for columns 2..6; empty slots are tied low.
  logic [6:2] row0;
  logic [6:2] row1;

  assign row0 = {pp[3][3], s5, s6, s4, s1};
  assign row1 = {c5, c6, 1'b0, 1'b0, 1'b0};

  // Final ripple-carry adder. Column 1 has no incoming carry, so a half
  // adder is enough there; cy[k] is the carry into column k.
  logic [7:0] sum;
  logic [7:2] cy;

  assign sum[0] = pp[0][0];

  wallace_ha u_rca1 (.a(pp[0][1]), .b(pp[1][0]), .s(sum[1]), .c(cy[2]));

  for (genvar k = 2; k < 7; k++) begin : g_rca
    wallace_fa u_rca (
      .a   (row0[k]),
      .b   (row1[k]),
      .cin (cy[k]),
      .s   (sum[k]),
      .cout(cy[k+1])
    );
  end

  // The carry out of column 6 is the product MSB; 15*15 = 225 fits exactly.
  assign sum[7] = cy[7];

  // Output register. prod is only loaded on a valid cycle, so operands that
  // are junk while in_valid=0 never reach it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod      <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        prod <= sum;
      end
    end
  end

endmodule

// Full adder cell (3:2 compressor).
module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Half adder cell (2:2 compressor).
module wallace_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: tb/tb_wallace_mult4.sv
// tb_wallace_mult4 - scoreboard bench for wallace_mult4.
// The driver issues one cycle of stimulus per call and, at the sampling
// edge, pushes the expected product into exp_q and updates the value prod
// must hold on idle cycles. The monitor runs on the falling edge: when
// out_valid is high it pops and compares, otherwise it checks that prod
// held its value.
module tb_wallace_mult4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] prod;
  logic       out_valid;

  logic [7:0] exp_q[$];
  logic [7:0] held;
  logic       mon_en;
  int         n_checks;
  int         n_fails;

  wallace_mult4 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .prod     (prod),
    .out_valid(out_valid)
  );

  // Clock and initial input state
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One stimulus cycle. Inputs change 1 time unit after a rising edge and
  // are sampled at the next one; the expectation is recorded at that edge.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic r, input logic [7:0] e);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    mon_en = 1'b1;
    if (r) begin
      held = 8'h00;
    end else if (v) begin
      exp_q.push_back(e);
      held = e;
    end
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL out_valid_unexpected: prod=%0d with no product expected", prod);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (prod !== e) begin
            n_fails++;
            $display("FAIL product: got %0d (0x%02h), expected %0d (0x%02h)", prod, prod, e, e);
          end
        end
      end else begin
        n_checks++;
        if (prod !== held) begin
          n_fails++;
          $display("FAIL hold: prod=%0d while out_valid=0, expected %0d", prod, held);
        end
      end
    end
  end

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] e;
  } vec_t;

  vec_t corners [7];

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 4'h0; B = 4'h0;
    held = 8'h00; mon_en = 1'b0;
    n_checks = 0; n_fails = 0;

    // Hand-computed corner products
    corners[0] = '{a: 4'd0,  b: 4'd0,  e: 8'd0};
    corners[1] = '{a: 4'd15, b: 4'd0,  e: 8'd0};
    corners[2] = '{a: 4'd0,  b: 4'd15, e: 8'd0};
    corners[3] = '{a: 4'd1,  b: 4'd15, e: 8'd15};
    corners[4] = '{a: 4'd15, b: 4'd15, e: 8'hE1};
    corners[5] = '{a: 4'd8,  b: 4'd8,  e: 8'd64};
    corners[6] = '{a: 4'd12, b: 4'd10, e: 8'd120};

    // Reset for two cycles; monitor checks prod=0, out_valid=0
    drive(1'b0, 4'd0, 4'd0, 1'b1, 8'd0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 8'd0);

    // Exhaustive sweep, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(1'b1, 4'(a), 4'(b), 1'b0, 8'(a * b));
      end
    end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 8'd0);

    // Corners, each followed by an idle cycle
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, corners[i].a, corners[i].b, 1'b0, corners[i].e);
      drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 8'd0);
    end

    // Hold: (7,9)=63, then three idle cycles with operands changing
    drive(1'b1, 4'd7, 4'd9, 1'b0, 8'd63);
    drive(1'b0, 4'd15, 4'd15, 1'b0, 8'd0);
    drive(1'b0, 4'd3,  4'd12, 1'b0, 8'd0);
    drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 8'd0);

    // Reset mid-stream: (15,15) with rst on the same edge is discarded
    drive(1'b1, 4'd15, 4'd15, 1'b1, 8'd0);
    drive(1'b1, 4'd3,  4'd5,  1'b0, 8'd15);
    drive(1'b0, 4'd0,  4'd0,  1'b0, 8'd0);

    // Back-to-back triple
    drive(1'b1, 4'd2, 4'd3, 1'b0, 8'd6);
    drive(1'b1, 4'd4, 4'd5, 1'b0, 8'd20);
    drive(1'b1, 4'd6, 4'd7, 1'b0, 8'd42);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 8'd0);
    drive(1'b0, 4'd0, 4'd0, 1'b0, 8'd0);

    // Every expected product must have been presented
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d products never presented, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wallace_mult4.md
Name: wallace_mult4

Overview:
- 4x4 unsigned multiplier built as an explicit Wallace-tree reduction, with one registered output stage.
- Used as a small arithmetic leaf wherever an 8-bit product of two 4-bit operands is needed.
- Also serves as the reference structure for wider Wallace multipliers in the multiply/divide library.

Parameters:
- none. Operand width is fixed at 4; product width is fixed at 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies A/B for capture this cycle.
- A  input  4  multiplicand, unsigned.
- B  input  4  multiplier, unsigned.
- prod  output  8  registered unsigned product A*B.
- out_valid  output  1  high for one cycle when prod holds a fresh product.

Behaviour:
- Reset: on a rising clk edge with rst=1, prod<=8'h00 and out_valid<=0. Reset has priority over in_valid. A reset issued while a product is in flight discards that product.
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge N, then after edge N prod = A*B sampled at edge N and out_valid=1.
  - If in_valid=0 at edge N, out_valid<=0 and prod holds its previous value.
- Throughput: one product per cycle. Back-to-back in_valid is fully supported with no bubbles.
- Partial products: pp[i][j] = A[j] & B[i], 16 AND terms, column weight i+j (0..6).
- Reduction:
  - Use Wallace-tree stages of explicit half and full adder cells (3:2 and 2:2 compressors).
  - Reduce each column until at most two rows remain.
  - Column 0 passes straight through as prod bit 0.
- Final adder:
  - Ripple-carry addition of the two remaining rows.
  - The carry out of column 6 forms prod[7].
  - No carry may be dropped. Max result 15*15=225 (8'hE1) fits exactly in 8 bits.
- Implementation rule: the datapath must not use the behavioural '*' operator. Half/full adders are separate modules or instantiated cells.
- Combinational path: A/B to the prod register D input is purely combinational, with no latches.
- X handling: X on A or B while in_valid=0 must not change prod or out_valid.
- All arithmetic is unsigned. No overflow or saturation is possible.

Test Plan:
- Exhaustive: assert rst for 2 cycles, then sweep A=0..15 x B=0..15 with in_valid=1 every cycle. Each prod one cycle later equals A*B, out_valid=1; score 256/256.
- Corners: (0,0)->0; (15,0)->0; (0,15)->0; (1,15)->15; (15,15)->225 (8'hE1); (8,8)->64; (12,10)->120.
- Hold: issue (7,9) with in_valid=1, then in_valid=0 for 3 cycles with A/B changing. prod stays 63 and out_valid pulses exactly one cycle.
- Reset mid-stream: drive (15,15) with in_valid=1 and rst=1 on the same edge. After that edge prod=0 and out_valid=0. Next valid (3,5) gives 15 one cycle later.
- Back-to-back: (2,3),(4,5),(6,7) on consecutive cycles -> prod 6,20,42 on consecutive cycles, out_valid held high for 3 cycles.
